// File: rtl/audio_rom_reader.sv
// Avalon-MM read master that streams ROM samples through a small FIFO onto an Avalon-ST source.
// Define AUDIO_ROM_READER_STEREO_EN to present every word as a left/right beat pair on sample_channel.
//
// state | meaning
// IDLE  | waiting for start, no reads outstanding
// FETCH | issuing reads in address order, paced by FIFO credit
// DRAIN | last word requested (single-shot), emptying FIFO
// FLUSH | stopped, discarding returns still in flight
module audio_rom_reader #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int NUM_WORDS    = 120127,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
`ifdef AUDIO_ROM_READER_STEREO_EN
    output logic              sample_channel,
`endif
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                    loop_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [READ_LATENCY-1:0] tag;
    logic [CNT_W-1:0]        inflight;
    logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    credit_ok;
    logic                    clear;
    logic                    ret;
    logic                    push;
    logic                    pop;

    // Outstanding reads count against FIFO space so a return always has a slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C;
    assign ret       = tag[READ_LATENCY-1];
    assign push      = ret && (state != FLUSH) && !clear;

    assign avm_address  = addr_q;
    assign sample_valid = (fifo_count != '0);
    assign sample_data  = fifo_mem[rd_ptr];
    assign busy         = (state != IDLE);

`ifdef AUDIO_ROM_READER_STEREO_EN
    logic ch_q;

    assign sample_channel = ch_q;
    assign pop            = sample_valid && sample_ready && ch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q <= 1'b0;
        end else if (clear) begin
            ch_q <= 1'b0;
        end else if (sample_valid && sample_ready) begin
            ch_q <= ~ch_q;
        end
    end
`else
    assign pop = sample_valid && sample_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        avm_read  = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    clear     = 1'b1;
                    state_nxt = FLUSH;
                end else if (credit_ok) begin
                    avm_read = 1'b1;
                    if ((addr_q == LAST_ADDR) && !loop_q) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (stop) begin
                    clear     = 1'b1;
                    state_nxt = FLUSH;
                end else if ((inflight == '0) && (fifo_count == '0)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (inflight == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_q   <= 1'b0;
            addr_q   <= '0;
            tag      <= '0;
            inflight <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                loop_q <= loop_en;
                addr_q <= '0;
            end else if (avm_read) begin
                // A single-shot run parks on the last address instead of wrapping.
                if (addr_q == LAST_ADDR) begin
                    addr_q <= loop_q ? '0 : addr_q;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            tag[0] <= avm_read;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            inflight <= inflight + CNT_W'(avm_read) - CNT_W'(ret);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr     <= wr_ptr;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= avm_readdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_audio_rom_reader.sv
// Self-checking bench for audio_rom_reader: scenario table plus hand sequences,
// checked against an address-order playback model of the expected beat stream.
`timescale 1ns/1ps
module tb_audio_rom_reader;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int NW     = 20;
    localparam int LAT    = 1;
    localparam int DEPTH  = 8;
`ifdef AUDIO_ROM_READER_STEREO_EN
    localparam int BPW = 2;
`else
    localparam int BPW = 1;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [DATA_W-1:0] avm_readdata;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;
`ifdef AUDIO_ROM_READER_STEREO_EN
    logic              sample_channel;
`endif

    audio_rom_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW),
        .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
`ifdef AUDIO_ROM_READER_STEREO_EN
        .sample_channel(sample_channel),
`endif
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rom_word(input int a);
        return (a * 2741 + 'h1F3B) & 'hFFFF;
    endfunction

    // ROM slave with latency 1; garbage on the bus when no read was issued.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= 16'(rom_word(int'(avm_address)));
        else          avm_readdata <= 16'($urandom);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: after an accepted start, reads walk addresses 0,1,.. mod NW and
    // beats deliver rom_word of successive addresses, BPW beats per word.
    int          rd_idx = 0;
    int          beat_idx = 0;
    int          words_popped = 0;
    int          done_cnt = 0;
    bit          playing = 0;
    bit          prev_done = 0;
    bit          prev_stall = 0;
    bit          stop_prev = 0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            playing    = 0;
            prev_done  = 0;
            prev_stall = 0;
            stop_prev  = 0;
        end else begin
            if (stop_prev) check("valid_after_stop", int'(sample_valid), 0);
            if (prev_stall && sample_valid) check("data_hold", int'(sample_data), int'(prev_data));
            if (avm_read) begin
                check("read_addr", int'(avm_address), rd_idx % NW);
                check("credit", int'((rd_idx + 1 - words_popped) <= DEPTH), 1);
                rd_idx++;
            end
            if (sample_valid && sample_ready) begin
                check("beat_while_idle", int'(playing), 1);
                check("beat_data", int'(sample_data), rom_word((beat_idx / BPW) % NW));
`ifdef AUDIO_ROM_READER_STEREO_EN
                check("beat_channel", int'(sample_channel), beat_idx % 2);
`endif
                beat_idx++;
                if (beat_idx % BPW == 0) words_popped++;
            end
            if (done) begin
                check("done_width", int'(prev_done), 0);
                done_cnt++;
            end
            prev_done  = done;
            prev_stall = sample_valid && !sample_ready;
            prev_data  = sample_data;
            stop_prev  = stop && busy;
            if (stop && busy) playing = 0;
            if (start && !busy) begin
                playing      = 1;
                rd_idx       = 0;
                beat_idx     = 0;
                words_popped = 0;
            end
        end
    end

    typedef struct {
        int loop;
        int ready_pct;
        int stop_after;
        int cycles;
        int exp_reads;
        int exp_beats;
        int min_beats;
        int exp_done;
        int exp_busy;
    } scen_t;

    scen_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        for (int c = 0; c < max_cycles && busy; c++) tick();
        check(name, int'(busy), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_avm_read"}, int'(avm_read), 0);
        check({tag, "_avm_address"}, int'(avm_address), 0);
        check({tag, "_sample_valid"}, int'(sample_valid), 0);
        check({tag, "_sample_data"}, int'(sample_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic run_scen(input int idx, input scen_t s);
        bit stopped = 0;
        done_cnt = 0;
        loop_en  = s.loop[0];
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < s.cycles; c++) begin
            stop         = 1'b0;
            sample_ready = ($urandom_range(99) < s.ready_pct);
            start        = (c == 6) && busy;
            if (!stopped && s.stop_after >= 0 && beat_idx == s.stop_after) begin
                stop         = 1'b1;
                sample_ready = 1'b0;
                start        = 1'b0;
                stopped      = 1;
            end
            tick();
            if (!busy && (stopped || s.loop == 0)) break;
        end
        stop  = 1'b0;
        start = 1'b0;
        if (s.exp_reads >= 0) check($sformatf("scen%0d_reads", idx), rd_idx, s.exp_reads);
        if (s.exp_beats >= 0) check($sformatf("scen%0d_beats", idx), beat_idx, s.exp_beats);
        if (s.min_beats > 0) check($sformatf("scen%0d_min_beats", idx), int'(beat_idx >= s.min_beats), 1);
        check($sformatf("scen%0d_done_cnt", idx), done_cnt, s.exp_done);
        check($sformatf("scen%0d_busy_end", idx), int'(busy), s.exp_busy);
        if (busy) begin
            sample_ready = 1'b0;
            stop         = 1'b1;
            tick();
            stop = 1'b0;
            wait_idle(20, $sformatf("scen%0d_cleanup_idle", idx));
            check($sformatf("scen%0d_cleanup_done", idx), done_cnt, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            loop ready stop    cyc  reads beats     min done busy
        tbl[0] = '{0, 100, -1,          300, NW, NW*BPW,    0,  1,   0};
        tbl[1] = '{0, 50,  -1,          600, NW, NW*BPW,    0,  1,   0};
        tbl[2] = '{1, 100, -1,          120, -1, -1,        45, 0,   1};
        tbl[3] = '{0, 100, 5,           300, -1, 5,         0,  1,   0};
        tbl[4] = '{1, 35,  33,          600, -1, 33,        0,  1,   0};
        tbl[5] = '{0, 100, 0,           50,  0,  0,         0,  1,   0};
        tbl[6] = '{0, 80,  NW*BPW-1,    400, -1, NW*BPW-1,  0,  1,   0};

        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        loop_en      = 1'b0;
        sample_ready = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // start and stop together in IDLE: start wins; then hold ready low to fill the FIFO
        done_cnt = 0;
        start    = 1'b1;
        stop     = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_wins", int'(busy), 1);
        for (int c = 0; c < 50; c++) tick();
        check("stall_reads", rd_idx, DEPTH);
        check("stall_read_low", int'(avm_read), 0);
        check("stall_valid", int'(sample_valid), 1);
        check("stall_head", int'(sample_data), rom_word(0));
        sample_ready = 1'b1;
        wait_idle(300, "stall_idle");
        check("stall_beats", beat_idx, NW * BPW);
        check("stall_total_reads", rd_idx, NW);
        check("stall_done_cnt", done_cnt, 1);

        for (int i = 0; i < 7; i++) run_scen(i, tbl[i]);

        // asynchronous reset while looping with reads in flight
        loop_en = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            sample_ready = ($urandom_range(99) < 60);
            tick();
        end
        #2 reset = 1'b1;
        #1 check_zero_outputs("midreset");
        tick();
        tick();
        reset        = 1'b0;
        done_cnt     = 0;
        loop_en      = 1'b0;
        sample_ready = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(300, "post_reset_idle");
        check("post_reset_beats", beat_idx, NW * BPW);
        check("post_reset_reads", rd_idx, NW);
        check("post_reset_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_rom_reader.md
Name: audio_rom_reader

Overview:
- Avalon-MM read master that streams 16-bit audio samples out of the on-chip sample ROM (a 17-bit word-addressed slave with fixed read latency) in address order.
- Fetched samples are buffered in a small internal FIFO and presented on an Avalon-ST source toward the audio codec output path.
- Supports single-shot and looped playback, abort via stop, and prefetch paced by downstream backpressure.

Parameters:
- ADDR_W, 17, ROM word-address width
- DATA_W, 16, sample width
- NUM_WORDS, 120127, number of valid ROM words; last address = NUM_WORDS-1
- READ_LATENCY, 1, cycles from read issue to avm_readdata valid (fixed, no waitrequest)
- FIFO_DEPTH, 8, sample buffer depth (power of 2, >=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin playback at address 0 (ignored unless IDLE)
- stop  in  1  one-cycle pulse; abort playback (ignored in IDLE)
- loop_en  in  1  sampled on start; 1 = wrap to address 0 after last word
- avm_address  out  ADDR_W  ROM word address
- avm_read  out  1  read strobe; one read per asserted cycle
- avm_readdata  in  DATA_W  ROM data, valid READ_LATENCY cycles after the read
- sample_data  out  DATA_W  ST source data
- sample_valid  out  1  ST valid
- sample_ready  in  1  ST ready from the codec path
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of non-looped playback or completed stop

Behaviour:
- Reset (async assert, sync release): state=IDLE; avm_address=0, avm_read=0, sample_valid=0, sample_data=0, busy=0, done=0. FIFO empty, in-flight count 0, latency shift register cleared.
- States: IDLE, FETCH, DRAIN, FLUSH.
- IDLE + start: latch loop_en, set address pointer to 0, go to FETCH.
- FETCH: assert avm_read when fifo_count + inflight < FIFO_DEPTH (credit rule; the FIFO never overflows).
  - Each issued read advances the pointer by 1.
  - Issuing address NUM_WORDS-1 with latched loop=1: pointer wraps to 0 and FETCH continues.
  - Issuing address NUM_WORDS-1 with loop=0: go to DRAIN with no further reads.
- Read return: a READ_LATENCY-deep valid shift register tags each issued read. When the tag emerges, push avm_readdata into the FIFO.
  - Returns are pushed in every state except FLUSH, where they are discarded.
- DRAIN: no reads. When inflight==0 and FIFO empty and no beat pending, pulse done for 1 cycle and go to IDLE.
- stop in FETCH or DRAIN: avm_read deasserts the same cycle the stop is sampled. FIFO is cleared, sample_valid drops next cycle, go to FLUSH.
- FLUSH: discard returns. When inflight==0, pulse done and go to IDLE.
- start outside IDLE is ignored. stop and start in the same cycle in IDLE: start wins. stop together with the last-address issue: stop wins.
- ST output: sample_valid = FIFO non-empty (registered head, or FIFO with registered output).
  - Beat transfers when sample_valid & sample_ready; FIFO pops on transfer.
  - sample_data holds stable while valid & !ready.
- Simultaneous push and pop on a full or empty FIFO is legal; count is unchanged.
- Samples are emitted in strict address order, none dropped or duplicated, except samples discarded by stop.
- avm_address holds its value when avm_read=0.

Optional Feature:
- Macro: AUDIO_ROM_READER_STEREO_EN.
- Defined:
  - Adds output port sample_channel (1 bit: 0 = left, 1 = right).
  - Each FIFO word is presented as two beats: channel 0, then channel 1, with the same data.
  - FIFO pops only when the channel-1 beat transfers.
  - stop or reset returns the channel to 0.
- Undefined: port absent; one beat per word.

Test Plan:
- Reset mid-FETCH with reads in flight -> all outputs 0 immediately, busy=0; a following start fetches from address 0.
- NUM_WORDS=20, loop_en=0, sample_ready=1, ROM data = address -> beats 0..19 in order, exactly 20 reads, then done pulses once and busy falls.
- NUM_WORDS=20, loop_en=1 -> beat sequence 0..19, 0, 1, ... continues; avm_address wraps 19->0; done never pulses.
- sample_ready=0 for 50 cycles after start, FIFO_DEPTH=8 -> at most 8 reads issued, then avm_read=0; sample_data=0 held. Releasing ready resumes with no loss.
- stop issued at sample 5 with 1 read in flight -> sample_valid=0 the next cycle, in-flight data discarded, done pulses; a new start restarts at sample 0.
- STEREO_EN, data 0xABCD -> two beats 0xABCD with sample_channel 0 then 1, a single FIFO pop; ready toggling 1/0 keeps the pairing intact.
